// File: rtl/accum_driver.sv
// Self-checking initiator for the 4-lane accumulator en/done four-phase handshake.
// Buffers add vectors in a small FIFO, tracks a shadow sum per lane and checks each returned accum.
module accum_driver #(
  parameter int ACCUM_WIDTH = 128,
  parameter int ADD_WIDTH   = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADD_WIDTH-1:0]   cmd_add [4],
  output logic                   en,
  output logic [ADD_WIDTH-1:0]   add [4],
  input  logic                   done,
  input  logic [ACCUM_WIDTH-1:0] accum [4],
  output logic                   busy,
  output logic [31:0]            txn_count,
  output logic [15:0]            err_count,
  output logic [3:0]             err_lanes,
  output logic                   timeout,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2, DRAIN = 2'd3} state_t;

  state_t                 state, state_nxt;
  logic [ADD_WIDTH-1:0]   mem [FIFO_DEPTH][4];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   empty, full, push, pop;
  logic [WD_W-1:0]        wdog;
  logic                   wd_hit, to_evt;
  logic [ACCUM_WIDTH-1:0] shadow [4];
  logic [ACCUM_WIDTH-1:0] exp_sum [4];
  logic [3:0]             mism;

  // cmd handshake: a vector transfers on a clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on the registered FIFO count, never on cmd_valid.
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE) || !empty;
  assign dbg_state = state;
  assign wd_hit    = (wdog == WD_W'(TIMEOUT));

  always_comb begin
    for (int i = 0; i < 4; i++) mism[i] = (accum[i] != exp_sum[i]);
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    to_evt    = 1'b0;
    case (state)
      IDLE: begin
        // A done still high from the previous transaction is a stale ack; wait it out.
        if (!empty && !done) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (done) begin
          state_nxt = REL;
        end else if (wd_hit) begin
          to_evt    = 1'b1;
          state_nxt = DRAIN;
        end
      end
      REL, DRAIN: begin
        if (!done) begin
          state_nxt = IDLE;
        end else if (wd_hit) begin
          to_evt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < 4; i++) mem[wr_ptr][i] <= cmd_add[i];
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en        <= 1'b0;
      wdog      <= '0;
      txn_count <= '0;
      err_count <= '0;
      err_lanes <= '0;
      timeout   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        add[i]     <= '0;
        shadow[i]  <= '0;
        exp_sum[i] <= '0;
      end
    end else begin
      en <= (state_nxt == REQ);
      if (state_nxt != state) wdog <= '0;
      else if (!wd_hit)       wdog <= wdog + WD_W'(1);
      if (pop) begin
        for (int i = 0; i < 4; i++) begin
          add[i]     <= mem[rd_ptr][i];
          exp_sum[i] <= shadow[i] + ACCUM_WIDTH'(mem[rd_ptr][i]);
        end
      end
      // Shadow follows the expected sum even on a mismatch, so one bad return is reported once.
      if (state == REQ && done) begin
        for (int i = 0; i < 4; i++) shadow[i] <= exp_sum[i];
        txn_count <= txn_count + 32'd1;
        if (|mism) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          err_lanes <= err_lanes | mism;
        end
      end
      if (to_evt) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_driver.sv
// Directed bench for accum_driver: behavioural accumulator, add-vector scoreboard and counter checks.
module tb_accum_driver;

  localparam int AW = 128;
  localparam int DW = 64;
  localparam int VW = 4 * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_add [4];
  logic          en;
  logic [DW-1:0] add [4];
  logic          done;
  logic [AW-1:0] accum [4];
  logic          busy;
  logic [31:0]   txn_count;
  logic [15:0]   err_count;
  logic [3:0]    err_lanes;
  logic          timeout;
  logic [1:0]    dbg_state;

  logic [VW-1:0] exp_q [$];
  logic [AW-1:0] sum [4];
  logic          stall;
  int            inj_at;
  int            model_txn;
  int            n_vec = 0;
  int            n_err = 0;
  logic          en_q = 1'b0;

  accum_driver #(.ACCUM_WIDTH(AW), .ADD_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_add(cmd_add),
    .en(en), .add(add), .done(done), .accum(accum), .busy(busy), .txn_count(txn_count),
    .err_count(err_count), .err_lanes(err_lanes), .timeout(timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  // Ideal accumulator: sum updates with done on the same edge; inj_at adds +1 to lane2 of one reply.
  always @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      model_txn <= 0;
      for (int i = 0; i < 4; i++) begin
        sum[i]   <= '0;
        accum[i] <= '0;
      end
    end else if (en && !done && !stall) begin
      for (int i = 0; i < 4; i++) begin
        sum[i]   <= sum[i] + AW'(add[i]);
        accum[i] <= sum[i] + AW'(add[i]) + ((model_txn == inj_at && i == 2) ? AW'(1) : AW'(0));
      end
      done      <= 1'b1;
      model_txn <= model_txn + 1;
    end else if (!en && done) begin
      done <= 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      en_q <= 1'b0;
    end else begin
      if (en && !en_q) begin
        n_vec = n_vec + 1;
        if (exp_q.size() == 0) begin
          n_err = n_err + 1;
          $display("FAIL add_vector: got %0h want <none queued>", {add[3], add[2], add[1], add[0]});
        end else begin
          logic [VW-1:0] want;
          want = exp_q.pop_front();
          if ({add[3], add[2], add[1], add[0]} !== want) begin
            n_err = n_err + 1;
            $display("FAIL add_vector: got %0h want %0h", {add[3], add[2], add[1], add[0]}, want);
          end
        end
      end
      en_q <= en;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] want);
    n_vec = n_vec + 1;
    if (got !== want) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_vec(input logic [DW-1:0] a0, a1, a2, a3);
    int w = 0;
    cmd_add[0] = a0; cmd_add[1] = a1; cmd_add[2] = a2; cmd_add[3] = a3;
    cmd_valid  = 1'b1;
    while (!cmd_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("push_wait", 0, 1);
    end else begin
      exp_q.push_back({a3, a2, a1, a0});
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || en || done) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (busy || en || done) check("wait_idle", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; stall = 1'b0; inj_at = -1;
    for (int i = 0; i < 4; i++) cmd_add[i] = '0;
    @(negedge clk);
    do_reset();

    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_txn", txn_count, 0);
    check("rst_err", err_count, 0);
    check("rst_lanes", err_lanes, 0);
    check("rst_timeout", timeout, 0);
    check("rst_add0", add[0], 0);
    check("rst_state", dbg_state, 0);

    // 1: single vector, en one cycle after the FIFO holds it
    push_vec(64'd1, 64'd2, 64'd3, 64'd4);
    check("t1_en_before_pop", en, 0);
    @(negedge clk);
    check("t1_en_after_pop", en, 1);
    wait_idle();
    check("t1_txn", txn_count, 1);
    check("t1_err", err_count, 0);
    check("t1_sum3", sum[3], 4);

    // 2: lane0 carries out of 64 bits into the 128-bit shadow
    do_reset();
    push_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0);
    push_vec(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd0);
    wait_idle();
    check("t2_txn", txn_count, 2);
    check("t2_err", err_count, 0);
    check("t2_sum0", sum[0], 128'h1_FFFF_FFFF_FFFF_FFFE);

    // 3: lane2 reply off by one on the first transaction only
    do_reset();
    inj_at = 0;
    push_vec(64'd10, 64'd20, 64'd30, 64'd40);
    wait_idle();
    check("t3_err_a", err_count, 1);
    check("t3_lanes_a", err_lanes, 4'b0100);
    push_vec(64'd1, 64'd1, 64'd1, 64'd1);
    wait_idle();
    inj_at = -1;
    check("t3_txn", txn_count, 2);
    check("t3_err_b", err_count, 1);
    check("t3_lanes_b", err_lanes, 4'b0100);

    // 4: five back-to-back vectors with the accumulator stalled fill the FIFO
    do_reset();
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) push_vec(DW'(k), DW'(k + 16), DW'(k + 32), DW'(k + 48));
    check("t4_ready_full", cmd_ready, 0);
    check("t4_busy", busy, 1);
    stall = 1'b0;
    wait_idle();
    check("t4_txn", txn_count, 5);
    check("t4_err", err_count, 0);
    check("t4_sum0", sum[0], 15);
    check("t4_sum3", sum[3], 255);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: no done for TIMEOUT+1 cycles aborts, next vector still completes
    do_reset();
    stall = 1'b1;
    push_vec(64'd7, 64'd0, 64'd0, 64'd0);
    @(negedge clk);
    begin
      int hi = 0;
      while (en && hi < 400) begin
        hi++;
        @(negedge clk);
      end
      check("t5_en_high_cycles", hi, 256);
    end
    check("t5_timeout", timeout, 1);
    check("t5_en", en, 0);
    check("t5_txn_abort", txn_count, 0);
    stall = 1'b0;
    push_vec(64'd5, 64'd0, 64'd0, 64'd0);
    wait_idle();
    check("t5_txn", txn_count, 1);
    check("t5_err", err_count, 0);
    check("t5_timeout_sticky", timeout, 1);
    check("t5_sum0", sum[0], 5);

    // 6: reset while en and done are both high, with vectors still queued
    do_reset();
    stall = 1'b1;
    push_vec(64'd1, 64'd0, 64'd0, 64'd0);
    push_vec(64'd2, 64'd0, 64'd0, 64'd0);
    push_vec(64'd3, 64'd0, 64'd0, 64'd0);
    stall = 1'b0;
    begin
      int w = 0;
      while (!(en && done) && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("t6_reach_en_done", en && done, 1);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("t6_en", en, 0);
    check("t6_busy", busy, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_txn", txn_count, 0);
    check("t6_err", err_count, 0);
    check("t6_timeout", timeout, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
